// File: rtl/avr_timer_prescaler.sv
// Clock-select and prescaler for avr_timer: divides clk by 1/8/64/256/1024 or
// follows synchronised T0 edges, and owns the GTCCR-style TSM/PSR register.
module avr_timer_prescaler #(
    parameter logic [5:0]  GTCCR_ADDR  = 6'h23,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] io_addr,
    inout  wire  [7:0] io_data,
    input  logic       io_read,
    input  logic       io_write,
    input  logic [2:0] cs,
    input  logic       T0,
    output logic       tick
);

    logic [9:0]             presc_q, presc_d;
    logic                   tsm_q, tsm_d;
    logic                   psr_q, psr_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   t0_hist_q;
    logic                   sel;
    logic                   t0_rise, t0_fall;
    logic                   unused_wdata;

    assign sel          = (io_addr == GTCCR_ADDR);
    assign unused_wdata = ^io_data[6:1];

    // A simultaneous write takes priority, so the block never drives against the writer.
    assign io_data = (io_read && !io_write && sel) ? {tsm_q, 6'b0, psr_q} : 'z;

    always_comb begin
        presc_d = psr_q ? '0 : presc_q + 10'd1;
        tsm_d   = tsm_q;
        psr_d   = psr_q;
        if (io_write && sel) begin
            tsm_d = io_data[7];
            psr_d = io_data[0];
        end else if (!tsm_q) begin
            psr_d = 1'b0;
        end
        sync_d = {sync_q[SYNC_STAGES-2:0], T0};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q   <= '0;
            tsm_q     <= 1'b0;
            psr_q     <= 1'b0;
            sync_q    <= '0;
            t0_hist_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            tsm_q     <= tsm_d;
            psr_q     <= psr_d;
            sync_q    <= sync_d;
            t0_hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign t0_rise = sync_q[SYNC_STAGES-1] & ~t0_hist_q;
    assign t0_fall = ~sync_q[SYNC_STAGES-1] & t0_hist_q;

    // Terminal counts are taken from the free-running counter; PSR masks only the divided taps.
    always_comb begin
        tick = 1'b0;
        case (cs)
            3'd0: tick = 1'b0;
            3'd1: tick = 1'b1;
            3'd2: tick = !psr_q && (presc_q[2:0] == 3'h7);
            3'd3: tick = !psr_q && (presc_q[5:0] == 6'h3f);
            3'd4: tick = !psr_q && (presc_q[7:0] == 8'hff);
            3'd5: tick = !psr_q && (presc_q == 10'h3ff);
            3'd6: tick = t0_fall;
            3'd7: tick = t0_rise;
            default: tick = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_avr_timer_prescaler.sv
// Randomised and directed bench for avr_timer_prescaler against a cycle-level
// reference model built from counter arithmetic and a T0 sample history.
module tb_avr_timer_prescaler;

    localparam logic [5:0]  ADDR = 6'h23;
    localparam int unsigned S    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] io_addr;
    logic       io_read, io_write;
    logic [2:0] cs;
    logic       T0;
    logic       tick;
    logic       tb_drv;
    logic [7:0] tb_wdata;
    wire  [7:0] io_data;

    always #5 clk = ~clk;

    assign io_data = tb_drv ? tb_wdata : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pull
        pullup (io_data[g]);
    end

    avr_timer_prescaler #(.GTCCR_ADDR(ADDR), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .io_addr(io_addr), .io_data(io_data),
        .io_read(io_read), .io_write(io_write), .cs(cs), .T0(T0), .tick(tick)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: prescaler value, register bits, and T0 samples (newest first).
    int  m_presc;
    bit  m_tsm, m_psr;
    bit  m_t0q[$];
    bit  t0_auto = 1'b0;
    int  t0_cnt = 0;
    logic       tick_obs;
    logic [7:0] io_obs;

    task automatic model_reset();
        m_presc = 0; m_tsm = 1'b0; m_psr = 1'b0;
        m_t0q.delete();
        repeat (S + 1) m_t0q.push_back(1'b0);
    endtask

    function automatic bit exp_tick();
        int n;
        bit rise, fall;
        rise = m_t0q[S-1] & ~m_t0q[S];
        fall = ~m_t0q[S-1] & m_t0q[S];
        case (cs)
            3'd0: return 1'b0;
            3'd1: return 1'b1;
            3'd6: return fall;
            3'd7: return rise;
            default: begin
                n = 1 << (3 * (int'(cs) - 1) - ((cs == 3'd4) ? 1 : 0) - ((cs == 3'd5) ? 0 : 0));
                // cs 2,3,4,5 -> 8,64,256,1024
                n = (cs == 3'd2) ? 8 : (cs == 3'd3) ? 64 : (cs == 3'd4) ? 256 : 1024;
                return !m_psr && ((m_presc % n) == n - 1);
            end
        endcase
    endfunction

    // One clock cycle: inputs are already set (at the falling edge); check, then advance model.
    task automatic step();
        logic [7:0] exp_rd;
        if (t0_auto) begin
            if (t0_cnt == 2) begin T0 = ~T0; t0_cnt = 0; end
            else t0_cnt++;
        end
        #1;
        tick_obs = tick;
        io_obs   = io_data;
        check("tick", {15'b0, tick}, {15'b0, exp_tick()});
        if (!io_write) begin
            exp_rd = (io_read && io_addr == ADDR) ? {m_tsm, 6'b0, m_psr} : 8'hff;
            check("io_data", {8'b0, io_data}, {8'b0, exp_rd});
        end
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            m_t0q.push_front(T0);
            void'(m_t0q.pop_back());
            m_presc = m_psr ? 0 : (m_presc + 1) % 1024;
            if (io_write && io_addr == ADDR) begin
                m_tsm = tb_wdata[7];
                m_psr = tb_wdata[0];
            end else if (!m_tsm) begin
                m_psr = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] d);
        io_addr = ADDR; io_write = 1'b1; tb_wdata = d; tb_drv = 1'b1;
        step();
        io_write = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic rd_expect(input string tag, input logic [7:0] exp);
        io_addr = ADDR; io_read = 1'b1;
        step();
        io_read = 1'b0;
        check(tag, {8'b0, io_obs}, {8'b0, exp});
    endtask

    task automatic wait_tick(input int max_cycles, output int idx);
        idx = -1;
        for (int i = 0; i < max_cycles; i++) begin
            step();
            if (tick_obs === 1'b1) begin idx = i; return; end
        end
    endtask

    task automatic run_period(input string tag, input int n);
        int last = -1;
        int cnt  = 0;
        for (int i = 0; i < 3 * n + 20 && cnt < 3; i++) begin
            step();
            if (tick_obs === 1'b1) begin
                if (last >= 0) check(tag, 16'(i - last), 16'(n));
                last = i;
                cnt++;
            end
        end
        check({tag, "_count"}, 16'(cnt), 16'd3);
    endtask

    task automatic count_ticks(input string tag, input int cycles, input int exp);
        int cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (tick_obs === 1'b1) cnt++;
        end
        check(tag, 16'(cnt), 16'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        rst = 1'b0; io_addr = '0; io_read = 1'b0; io_write = 1'b0;
        cs = 3'd0; T0 = 1'b0; tb_drv = 1'b0; tb_wdata = '0;
        model_reset();
        @(negedge clk);
        repeat (3) step();
        rst = 1'b1;
        rd_expect("rst_read", 8'h00);

        cs = 3'd1; count_ticks("cs1_every", 20, 20);
        cs = 3'd0; count_ticks("cs0_stopped", 100, 0);

        cs = 3'd2; run_period("period8", 8);
        cs = 3'd3; run_period("period64", 64);
        cs = 3'd4; run_period("period256", 256);
        cs = 3'd5; run_period("period1024", 1024);

        t0_auto = 1'b1;
        cs = 3'd7; run_period("t0_rise_gap", 6);
        cs = 3'd6; run_period("t0_fall_gap", 6);
        t0_auto = 1'b0;

        // PSR write with TSM=0 mid-count on cs=3.
        cs = 3'd3;
        repeat (20) step();
        wr(8'h01);
        step();
        rd_expect("psr_selfclear", 8'h00);
        wait_tick(100, idx);
        check("psr_realign", 16'(idx), 16'd62);
        repeat (63) step();
        wr(8'h01);
        check("tick_in_write_cycle", {15'b0, tick_obs}, 16'd1);
        repeat (3) step();

        // TSM holds PSR: divided taps silent, cs=1 still ticks.
        wr(8'h81);
        rd_expect("tsm_hold_read", 8'h81);
        for (int c = 2; c <= 5; c++) begin
            cs = 3'(c);
            count_ticks("held_no_tick", 30, 0);
        end
        cs = 3'd1; count_ticks("held_cs1", 10, 10);
        cs = 3'd2;
        wr(8'h00);
        wait_tick(20, idx);
        check("release_gap", 16'(idx), 16'd7);

        // Reset mid cs=4 count with TSM set.
        cs = 3'd4;
        wr(8'h80);
        repeat (100) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        rd_expect("rst_tsm_clear", 8'h00);
        wait_tick(300, idx);
        check("rst_first_tick", 16'(idx), 16'd254);

        // Random traffic, all checked cycle by cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(19) == 0) cs = 3'($urandom_range(7));
            if ($urandom_range(2) == 0) T0 = ~T0;
            io_addr  = ($urandom_range(3) == 0) ? 6'($urandom) : ADDR;
            io_read  = ($urandom_range(3) == 0);
            io_write = ($urandom_range(14) == 0);
            tb_drv   = io_write;
            tb_wdata = 8'($urandom);
            if (tb_wdata[7] && $urandom_range(1) == 0) tb_wdata[7] = 1'b0;
            rst = ($urandom_range(199) != 0);
            step();
            io_read = 1'b0; io_write = 1'b0; tb_drv = 1'b0; rst = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
